instr_fetch_queue: RTL and testbench



---
 rtl/instr_fetch_queue.sv | 144 ++++++++++++++
 tb/tb_instr_fetch_queue.sv | 358 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_queue.sv
// Instruction fetch front-end: sequential fetch over a req/ack memory port, a
// small PC-tagged prefetch FIFO for decode, and branch-redirect flush.
module instr_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'd0
) (
  input  logic        clk_i,
  input  logic        rst_n,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_ack_i,
  input  logic [31:0] mem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] instr_pc_o,
  input  logic        instr_ready_i,
  output logic [31:0] fetch_pc_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_WAIT = 2'd1;
  localparam logic [1:0] ST_DROP = 2'd2;

  logic [1:0]       state;
  logic [31:0]      fetch_pc;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] count;
  logic [CNT_W-1:0] occ;
  logic [31:0]      pc_mem   [DEPTH];
  logic [31:0]      data_mem [DEPTH];
  logic [31:0]      redirect_target;
  logic             issue;
  logic             push;
  logic             pop;
  logic             unused_pc_bits;

  assign redirect_target = {redirect_pc_i[31:2], 2'b00};
  assign unused_pc_bits  = ^redirect_pc_i[1:0];

  // A fetch in flight already owns a FIFO slot, so its ack can never overflow.
  assign occ = count + CNT_W'(state == ST_WAIT);

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    issue = 1'b0;
    push  = 1'b0;
    pop   = 1'b0;
    if (!redirect_i) begin
      issue = (state == ST_IDLE) && (occ < CNT_W'(DEPTH));
      push  = (state == ST_WAIT) && mem_ack_i;
      pop   = instr_valid_o && instr_ready_i;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of block ordering.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      mem_req_o  <= 1'b0;
      mem_addr_o <= RESET_PC;
    end else begin
      case (state)
        ST_IDLE: begin
          if (issue) begin
            mem_req_o  <= 1'b1;
            mem_addr_o <= fetch_pc;
            state      <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= ST_IDLE;
          end else if (redirect_i) begin
            state <= ST_DROP;
          end
        end
        ST_DROP: begin
          // The memory must still complete the stale access; its data is dropped.
          if (mem_ack_i) begin
            mem_req_o <= 1'b0;
            state     <= ST_IDLE;
          end
        end
        default: begin
          mem_req_o <= 1'b0;
          state     <= ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
    end else if (redirect_i) begin
      fetch_pc <= redirect_target;
    end else if (push) begin
      fetch_pc <= fetch_pc + 32'd4;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (redirect_i) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; the head outputs are gated by count,
  // so stale entries are never observable.
  always_ff @(posedge clk_i) begin
    if (push) begin
      pc_mem[wr_ptr]   <= fetch_pc;
      data_mem[wr_ptr] <= mem_rdata_i;
    end
  end

  assign instr_valid_o = (count != '0);
  assign instr_o       = instr_valid_o ? data_mem[rd_ptr] : 32'd0;
  assign instr_pc_o    = instr_valid_o ? pc_mem[rd_ptr]   : 32'd0;
  assign fetch_pc_o    = fetch_pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Self-checking bench for instr_fetch_queue: directed scenarios plus a
// randomized run scored against a queue-based behavioural model.
module tb_instr_fetch_queue;

  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'd0;

  logic        clk_i = 1'b0;
  logic        rst_n;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_ack_i;
  logic [31:0] mem_rdata_i;
  logic        redirect_i;
  logic [31:0] redirect_pc_i;
  logic        instr_valid_o;
  logic [31:0] instr_o;
  logic [31:0] instr_pc_o;
  logic        instr_ready_i;
  logic [31:0] fetch_pc_o;

  always #5 clk_i = ~clk_i;

  instr_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk_i         (clk_i),
    .rst_n         (rst_n),
    .mem_req_o     (mem_req_o),
    .mem_addr_o    (mem_addr_o),
    .mem_ack_i     (mem_ack_i),
    .mem_rdata_i   (mem_rdata_i),
    .redirect_i    (redirect_i),
    .redirect_pc_i (redirect_pc_i),
    .instr_valid_o (instr_valid_o),
    .instr_o       (instr_o),
    .instr_pc_o    (instr_pc_o),
    .instr_ready_i (instr_ready_i),
    .fetch_pc_o    (fetch_pc_o)
  );

  int checks   = 0;
  int failures = 0;

  // Behavioural model: queue of {pc, instr}, one outstanding request flag,
  // and a flag marking that request's data as doomed by a redirect.
  logic [63:0] m_q[$];
  bit          m_req;
  bit          m_discard;
  logic [31:0] m_addr;
  logic [31:0] m_pc;

  int busy_cnt = 0;
  int cur_lat  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'd0) return 32'h20010005;
    if (a == 32'd4) return 32'h20020007;
    return (a * 32'h9E3779B1) ^ 32'h5A5A0000;
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_req     = 1'b0;
    m_discard = 1'b0;
    m_addr    = RESET_PC;
    m_pc      = RESET_PC;
    busy_cnt  = 0;
  endtask

  task automatic model_update(input logic ack, input logic [31:0] rdata,
                              input logic redir, input logic [31:0] rpc,
                              input logic rdy);
    int sz;
    sz = m_q.size();
    if (sz > 0 && rdy && !redir) void'(m_q.pop_front());
    if (redir) begin
      m_q.delete();
      m_pc = {rpc[31:2], 2'b00};
      if (m_req) begin
        if (ack) begin
          m_req     = 1'b0;
          m_discard = 1'b0;
        end else begin
          m_discard = 1'b1;
        end
      end
    end else if (m_req) begin
      if (ack) begin
        if (!m_discard) begin
          m_q.push_back({m_addr, rdata});
          m_pc = m_pc + 32'd4;
        end
        m_req     = 1'b0;
        m_discard = 1'b0;
      end
    end else if (sz < DEPTH) begin
      m_req  = 1'b1;
      m_addr = m_pc;
    end
  endtask

  // Drive one cycle of inputs (called at posedge+1), advance, update the model.
  task automatic step(input logic ack, input logic [31:0] rdata,
                      input logic redir, input logic [31:0] rpc, input logic rdy);
    mem_ack_i     = ack;
    mem_rdata_i   = rdata;
    redirect_i    = redir;
    redirect_pc_i = rpc;
    instr_ready_i = rdy;
    @(posedge clk_i);
    model_update(ack, rdata, redir, rpc, rdy);
    #1;
  endtask

  // Memory responder: ack after `lat` cycles of visible request; lat<0 picks
  // a random latency per request and sprinkles unsolicited acks in idle cycles.
  task automatic mem_step(input int lat, input logic rdy, input logic redir,
                          input logic [31:0] rpc);
    logic        ack;
    logic [31:0] rdata;
    ack   = 1'b0;
    rdata = (lat < 0) ? $urandom : mem_word(mem_addr_o);
    if (mem_req_o) begin
      if (busy_cnt == 0) cur_lat = (lat < 0) ? int'($urandom_range(0, 3)) : lat;
      if (busy_cnt == cur_lat) begin
        ack      = 1'b1;
        busy_cnt = 0;
      end else begin
        busy_cnt++;
      end
    end else begin
      ack      = (lat < 0) && ($urandom_range(0, 7) == 0);
      busy_cnt = 0;
    end
    step(ack, rdata, redir, rpc, rdy);
  endtask

  task automatic drive_idle_inputs();
    mem_ack_i     = 1'b0;
    mem_rdata_i   = 32'd0;
    redirect_i    = 1'b0;
    redirect_pc_i = 32'd0;
    instr_ready_i = 1'b0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    drive_idle_inputs();
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    drive_idle_inputs();
    model_reset();
    #2;
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL reset_req got=%0h exp=0", mem_req_o); end
    checks++; if (mem_addr_o !== RESET_PC) begin failures++; $display("FAIL reset_addr got=%h exp=%h", mem_addr_o, RESET_PC); end
    checks++; if (fetch_pc_o !== RESET_PC) begin failures++; $display("FAIL reset_fetch_pc got=%h exp=%h", fetch_pc_o, RESET_PC); end
    checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", instr_valid_o); end
    checks++; if (instr_o !== 32'd0) begin failures++; $display("FAIL reset_instr got=%h exp=0", instr_o); end
    checks++; if (instr_pc_o !== 32'd0) begin failures++; $display("FAIL reset_instr_pc got=%h exp=0", instr_pc_o); end
    do_reset();
  endtask

  task automatic test_basic_fetch();
    int          pops;
    logic [31:0] pcs [2];
    logic [31:0] ins [2];
    logic [31:0] fpc_second;
    pops       = 0;
    fpc_second = 32'hFFFF_FFFF;
    pcs[0] = '1; pcs[1] = '1; ins[0] = '1; ins[1] = '1;
    do_reset();
    for (int i = 0; i < 40 && pops < 2; i++) begin
      if (instr_valid_o) begin
        pcs[pops] = instr_pc_o;
        ins[pops] = instr_o;
        if (pops == 1) fpc_second = fetch_pc_o;
        pops++;
      end
      mem_step(1, 1'b1, 1'b0, 32'd0);
    end
    checks++; if (pops != 2) begin failures++; $display("FAIL basic_pop_count got=%0d exp=2", pops); end
    checks++; if (pcs[0] !== 32'd0) begin failures++; $display("FAIL basic_pc0 got=%h exp=0", pcs[0]); end
    checks++; if (ins[0] !== 32'h20010005) begin failures++; $display("FAIL basic_instr0 got=%h exp=20010005", ins[0]); end
    checks++; if (pcs[1] !== 32'd4) begin failures++; $display("FAIL basic_pc1 got=%h exp=4", pcs[1]); end
    checks++; if (ins[1] !== 32'h20020007) begin failures++; $display("FAIL basic_instr1 got=%h exp=20020007", ins[1]); end
    checks++; if (fpc_second !== 32'd8) begin failures++; $display("FAIL basic_fetch_pc got=%h exp=8", fpc_second); end
  endtask

  task automatic test_full();
    int          nreq;
    logic [31:0] addrs [8];
    do_reset();
    nreq = 0;
    for (int i = 0; i < 20; i++) begin
      if (mem_req_o) begin
        if (nreq < 8) addrs[nreq] = mem_addr_o;
        nreq++;
      end
      mem_step(0, 1'b0, 1'b0, 32'd0);
    end
    checks++; if (nreq != 4) begin failures++; $display("FAIL full_req_count got=%0d exp=4", nreq); end
    for (int i = 0; i < 4 && i < nreq; i++) begin
      checks++; if (addrs[i] !== 32'(i * 4)) begin failures++; $display("FAIL full_addr%0d got=%h exp=%h", i, addrs[i], 32'(i * 4)); end
    end
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL full_req_idle got=%0h exp=0", mem_req_o); end
    mem_step(0, 1'b1, 1'b0, 32'd0);
    checks++; if (instr_pc_o !== 32'd4) begin failures++; $display("FAIL full_head_after_pop got=%h exp=4", instr_pc_o); end
    nreq = 0;
    for (int i = 0; i < 10; i++) begin
      if (mem_req_o) begin
        if (nreq < 8) addrs[nreq] = mem_addr_o;
        nreq++;
      end
      mem_step(0, 1'b0, 1'b0, 32'd0);
    end
    checks++; if (nreq != 1) begin failures++; $display("FAIL full_refill_count got=%0d exp=1", nreq); end
    checks++; if (nreq >= 1 && addrs[0] !== 32'd16) begin failures++; $display("FAIL full_refill_addr got=%h exp=10", addrs[0]); end
  endtask

  task automatic test_redirect_idle();
    int acks;
    do_reset();
    acks = 0;
    for (int i = 0; i < 30 && acks < 3; i++) begin
      if (mem_req_o) acks++;
      mem_step(0, 1'b0, 1'b0, 32'd0);
    end
    checks++; if (acks != 3) begin failures++; $display("FAIL redir_idle_fill got=%0d exp=3", acks); end
    mem_step(0, 1'b0, 1'b1, 32'h00000042);
    checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL redir_idle_flush got=%0h exp=0", instr_valid_o); end
    checks++; if (fetch_pc_o !== 32'h40) begin failures++; $display("FAIL redir_idle_fetch_pc got=%h exp=40", fetch_pc_o); end
    mem_step(0, 1'b0, 1'b0, 32'd0);
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL redir_idle_req got=%0h exp=1", mem_req_o); end
    checks++; if (mem_addr_o !== 32'h40) begin failures++; $display("FAIL redir_idle_addr got=%h exp=40", mem_addr_o); end
    mem_step(0, 1'b0, 1'b0, 32'd0);
    checks++; if (instr_pc_o !== 32'h40) begin failures++; $display("FAIL redir_idle_head_pc got=%h exp=40", instr_pc_o); end
    checks++; if (instr_o !== mem_word(32'h40)) begin failures++; $display("FAIL redir_idle_head_instr got=%h exp=%h", instr_o, mem_word(32'h40)); end
  endtask

  task automatic test_redirect_wait();
    bit found;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req_o && mem_addr_o == 32'h8) begin
        found = 1'b1;
        break;
      end
      mem_step(0, 1'b0, 1'b0, 32'd0);
    end
    checks++; if (!found) begin failures++; $display("FAIL redir_wait_reach got=0 exp=1"); end
    step(1'b0, 32'd0, 1'b1, 32'h100, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8) begin failures++; $display("FAIL redir_wait_hold%0d got=%0h/%h exp=1/8", i, mem_req_o, mem_addr_o); end
      step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    end
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h8) begin failures++; $display("FAIL redir_wait_hold2 got=%0h/%h exp=1/8", mem_req_o, mem_addr_o); end
    step(1'b1, 32'hDEADBEEF, 1'b0, 32'd0, 1'b0);
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL redir_wait_release got=%0h exp=0", mem_req_o); end
    checks++; if (instr_valid_o !== 1'b0 || instr_o !== 32'd0) begin failures++; $display("FAIL redir_wait_discard got=%0h/%h exp=0/0", instr_valid_o, instr_o); end
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h100) begin failures++; $display("FAIL redir_wait_new_req got=%0h/%h exp=1/100", mem_req_o, mem_addr_o); end
  endtask

  task automatic test_redirect_with_ack();
    do_reset();
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checks++; if (mem_req_o !== 1'b1) begin failures++; $display("FAIL redir_ack_setup got=%0h exp=1", mem_req_o); end
    step(1'b1, 32'h11111111, 1'b1, 32'h200, 1'b0);
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL redir_ack_no_drop got=%0h exp=0", mem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL redir_ack_discard got=%0h exp=0", instr_valid_o); end
    checks++; if (fetch_pc_o !== 32'h200) begin failures++; $display("FAIL redir_ack_fetch_pc got=%h exp=200", fetch_pc_o); end
    step(1'b0, 32'd0, 1'b0, 32'd0, 1'b0);
    checks++; if (mem_req_o !== 1'b1 || mem_addr_o !== 32'h200) begin failures++; $display("FAIL redir_ack_new_req got=%0h/%h exp=1/200", mem_req_o, mem_addr_o); end
  endtask

  task automatic test_async_reset();
    bit found;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 30; i++) begin
      if (mem_req_o && instr_valid_o) begin
        found = 1'b1;
        break;
      end
      mem_step(0, 1'b0, 1'b0, 32'd0);
    end
    checks++; if (!found) begin failures++; $display("FAIL arst_reach got=0 exp=1"); end
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (mem_req_o !== 1'b0) begin failures++; $display("FAIL arst_req got=%0h exp=0", mem_req_o); end
    checks++; if (instr_valid_o !== 1'b0) begin failures++; $display("FAIL arst_valid got=%0h exp=0", instr_valid_o); end
    checks++; if (instr_o !== 32'd0) begin failures++; $display("FAIL arst_instr got=%h exp=0", instr_o); end
    drive_idle_inputs();
    model_reset();
    @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (mem_req_o) begin
        found = 1'b1;
        break;
      end
      mem_step(0, 1'b0, 1'b0, 32'd0);
    end
    checks++; if (!found || mem_addr_o !== RESET_PC) begin failures++; $display("FAIL arst_first_req got=%0d/%h exp=1/%h", found, mem_addr_o, RESET_PC); end
  endtask

  task automatic test_random();
    logic        redir;
    logic [31:0] rpc;
    logic        rdy;
    logic [63:0] head;
    do_reset();
    mem_step(-1, 1'b0, 1'b1, 32'hFFFFFFF5);
    for (int i = 0; i < 3000; i++) begin
      redir = ($urandom_range(0, 15) == 0);
      rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFFFFF0 | 32'($urandom_range(0, 15))) : $urandom;
      rdy   = 1'($urandom_range(0, 1));
      mem_step(-1, rdy, redir, rpc);
      head = (m_q.size() > 0) ? m_q[0] : 64'd0;
      checks++; if (mem_req_o !== m_req) begin failures++; $display("FAIL rand_req cyc=%0d got=%0h exp=%0h", i, mem_req_o, m_req); end
      if (m_req) begin
        checks++; if (mem_addr_o !== m_addr) begin failures++; $display("FAIL rand_addr cyc=%0d got=%h exp=%h", i, mem_addr_o, m_addr); end
      end
      checks++; if (fetch_pc_o !== m_pc) begin failures++; $display("FAIL rand_fetch_pc cyc=%0d got=%h exp=%h", i, fetch_pc_o, m_pc); end
      checks++; if (instr_valid_o !== (m_q.size() > 0)) begin failures++; $display("FAIL rand_valid cyc=%0d got=%0h exp=%0d", i, instr_valid_o, m_q.size() > 0); end
      checks++; if ({instr_pc_o, instr_o} !== head) begin failures++; $display("FAIL rand_head cyc=%0d got=%h/%h exp=%h/%h", i, instr_pc_o, instr_o, head[63:32], head[31:0]); end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic_fetch();
    test_full();
    test_redirect_idle();
    test_redirect_wait();
    test_redirect_with_ack();
    test_async_reset();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
